// File: rtl/icache_refill_ctrl.sv
// ICache miss refill: one 4-beat AXI4 INCR read per miss, assembled into a
// 128-bit line and written into the cache in a single cycle.
module icache_refill_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_valid,
  input  logic [31:0]  miss_pc,
  input  logic         miss_way,
  output logic         miss_ready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic         ICache_Wena,
  output logic         update_way,
  output logic [31:0]  update_pc,
  output logic [127:0] ICache_line,
  output logic         refill_done,
  output logic         refill_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RDATA,
    S_WRITE,
    S_ERR
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic [31:0] pc_reg;
  logic        way_reg;
  logic [1:0]  k_reg;
  logic        err_reg;
  logic [31:0] word_reg [4];

  logic beat_fire;
  logic beat_err;
  logic unused_rid;

  assign unused_rid = ^rid;
  assign beat_fire  = (state_reg == S_RDATA) && rvalid;
  // rlast must coincide exactly with the fourth beat; anything else poisons the line.
  assign beat_err   = (rresp != 2'b00) || (rlast != (k_reg == 2'd3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      pc_reg    <= '0;
      way_reg   <= 1'b0;
      k_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && miss_valid) begin
        addr_reg <= {miss_pc[31:4], 4'b0000};
        pc_reg   <= miss_pc;
        way_reg  <= miss_way;
        k_reg    <= '0;
        err_reg  <= 1'b0;
      end
      if (beat_fire) begin
        k_reg <= k_reg + 2'd1;
        if (beat_err) err_reg <= 1'b1;
      end
    end
  end

  // Beat k lands in word k, so beat 0 ends up in line bits [31:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg[gi] <= '0;
        end else if (beat_fire && k_reg == 2'(gi)) begin
          word_reg[gi] <= rdata;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (miss_valid) state_next = S_ADDR;
      S_ADDR:  if (arready) state_next = S_RDATA;
      S_RDATA: begin
        // Burst length is decided by the counter alone, never by rlast.
        if (rvalid && k_reg == 2'd3) begin
          state_next = (err_reg || beat_err) ? S_ERR : S_WRITE;
        end
      end
      S_WRITE: state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign miss_ready  = (state_reg == S_IDLE);
  assign arvalid     = (state_reg == S_ADDR);
  assign rready      = (state_reg == S_RDATA);
  assign ICache_Wena = (state_reg == S_WRITE);
  assign refill_done = (state_reg == S_WRITE);
  assign refill_err  = (state_reg == S_ERR);

  assign arid        = 4'd0;
  assign araddr      = addr_reg;
  assign arlen       = 8'd3;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign update_way  = way_reg;
  assign update_pc   = pc_reg;
  assign ICache_line = {word_reg[3], word_reg[2], word_reg[1], word_reg[0]};

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling stage for `ICache_unit`. It accepts a single instruction-cache miss and issues one 4-beat AXI4 INCR read burst for the 16-byte line. It assembles the returned beats into a 128-bit line and writes that line into the cache in one cycle through the cache's update port. The block sits between the ICache hit/miss logic (upstream) and the AXI read channels of the memory interconnect (downstream), and handles one outstanding miss at a time.

## Interface
- No parameters. Fixed values: line 128 bits, beat 32 bits, 4 beats per line, AXI ID 4 bits.
- Reset is `rst`: asynchronous, active-low. Clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-low reset
- `miss_valid`  in  1  upstream miss request
- `miss_pc`  in  32  PC that missed
- `miss_way`  in  1  victim way (`replace_way` from the cache)
- `miss_ready`  out  1  high only in IDLE; the miss is accepted when `miss_valid && miss_ready`
- `arid`  out  4  constant 0
- `araddr`  out  32  `{miss_pc[31:4], 4'b0}` (latched value)
- `arlen`  out  8  constant 3
- `arsize`  out  3  constant 3'b010
- `arburst`  out  2  constant 2'b01 (INCR)
- `arvalid`  out  1  AR request valid
- `arready`  in  1  AR accepted
- `rid`  in  4  ignored
- `rdata`  in  32  read beat
- `rresp`  in  2  beat response
- `rlast`  in  1  last-beat flag
- `rvalid`  in  1  beat valid
- `rready`  out  1  high only in RDATA
- `ICache_Wena`  out  1  one-cycle line write strobe
- `update_way`  out  1  latched `miss_way`
- `update_pc`  out  32  latched `miss_pc`
- `ICache_line`  out  128  assembled line
- `refill_done`  out  1  one-cycle pulse: line written
- `refill_err`  out  1  one-cycle pulse: refill aborted, nothing written

## Operation
States are IDLE, ADDR, RDATA, WRITE and ERR. Reset forces IDLE.

- **IDLE**
  - `miss_ready` = 1.
  - On handshake: latch `miss_pc` and `miss_way`, clear the beat counter and the error flag, then go to ADDR.
- **ADDR**
  - `arvalid` = 1. `araddr` is stable until `arready`.
  - On `arvalid && arready`, go to RDATA.
- **RDATA**
  - `rready` = 1. On each `rvalid`, the 2-bit beat counter `k` selects where `rdata` goes: `line[32k+31:32k]`. Beat 0 lands in bits [31:0], matching the cache's word order. Then `k` increments.
  - The sticky error flag is set by any of:
    - `rresp != 2'b00`;
    - `rlast` = 1 while `k != 3`;
    - `rlast` = 0 while `k == 3`.
  - After the beat with `k == 3` is accepted, go to WRITE if the flag is clear, otherwise go to ERR.
  - The burst length is governed only by the beat counter.
- **WRITE**
  - Exactly one cycle with `ICache_Wena` = 1 and `refill_done` = 1.
  - `update_way`, `update_pc` and `ICache_line` hold the latched values.
  - Then go to IDLE.
- **ERR**
  - Exactly one cycle with `refill_err` = 1 and `ICache_Wena` = 0. Then go to IDLE.
  - Upstream re-presents the miss if it needs to.
- **Outputs outside their active state:**
  - `arvalid`, `rready`, `ICache_Wena`, `refill_done` and `refill_err` are 0.
  - `update_*`, `ICache_line` and `araddr` keep their last latched values.
- **Reset values:** state IDLE; `miss_ready` = 1; all strobes = 0; `araddr`, `update_pc`, `ICache_line` = 0; `update_way` = 0; counter = 0; error flag = 0.
- **Reset mid-burst:** the block returns to IDLE immediately and discards any partial line. Beats of the abandoned burst that are still in flight are the interconnect's responsibility, because the block keeps `rready` = 0 in IDLE.
- `miss_valid` while busy is simply not accepted; no queueing.

## Timing
- Miss handshake at edge E0. `arvalid` is high in cycle E0+1.
- With `arready` = 1 in that cycle and `rvalid` = 1 every cycle from E0+2:
  - beats are accepted at E0+2 through E0+5;
  - the `ICache_Wena` cycle is E0+6;
  - `miss_ready` = 1 again at E0+7.
- The minimum miss-to-write latency is therefore 6 cycles. Each `arready` or `rvalid` stall adds one cycle per stalled cycle.
- All outputs are registered or decoded directly from state. There is no combinational path from `miss_valid` to `arvalid`, or from `rvalid` to `ICache_Wena`.

## Test plan
- **Basic refill:** reset, then `miss_pc` = 0x1C000124, `miss_way` = 1. With `arready` and `rvalid` always 1 and data 0x11111111, 0x22222222, 0x33333333, 0x44444444 (`rlast` on beat 4):
  - `araddr` = 0x1C000120, `arlen` = 3, `arsize` = 2, `arburst` = 1;
  - at E0+6: `ICache_Wena` = 1, `update_way` = 1, `update_pc` = 0x1C000124, `ICache_line` = 0x44444444_33333333_22222222_11111111.
- **Stalls:** `arready` low for 3 cycles and one bubble on `rvalid` → `araddr` is stable while stalled, the write lands at E0+10, and the line is the same as in the basic refill.
- **Error response:** `rresp` = 2'b10 on beat 1 → all 4 beats are still consumed, `refill_err` pulses once, `ICache_Wena` never rises, and `miss_ready` returns.
- **Bad rlast:** `rlast` = 1 on beat 2 → `refill_err` pulses and nothing is written. Separately, `rlast` = 0 on beat 4 → `refill_err` pulses.
- **Back-to-back and busy:**
  - `miss_valid` held high with a new PC → it is not accepted until the cycle after WRITE;
  - the second burst's `araddr` reflects the new PC.
- **Reset mid-burst:** drop `rst` after beat 2 → IDLE, `rready` = 0, strobes 0, `ICache_line` = 0 asynchronously. A fresh miss afterwards completes normally.
